// File: rtl/within_checker.sv
// ---------------------------------------------------------------------------
// within_checker
//
// Per-channel temporal checker for the property
//   "once b rises, b holds for OUTER_LEN cycles, c arrives on the cycle after,
//    and somewhere in that window a is high for INNER_LEN consecutive cycles".
// Each channel runs an IDLE -> OUTER -> TERM FSM, reports a one-cycle pass or
// fail pulse at the deciding edge, and keeps the cause of its latest failure.
// Saturating aggregate counters sum the pulses of all channels.
//
// Ports
//   clk        in   clock, all sampling on the rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   checker enable; low aborts every open window
//   clr_cnt    in   synchronous clear of pass_cnt / fail_cnt
//   a          in   [NCH]    inner-sequence signal
//   b          in   [NCH]    trigger and outer-hold signal
//   c          in   [NCH]    outer-terminator signal
//   busy       out  [NCH]    window open (stays high through the decision cycle)
//   pass       out  [NCH]    one-cycle pass pulse
//   fail       out  [NCH]    one-cycle fail pulse
//   fail_code  out  [2*NCH]  01 b dropped, 10 c missing, 11 inner run missing
//   pass_cnt   out  [CNT_W]  saturating total of pass pulses
//   fail_cnt   out  [CNT_W]  saturating total of fail pulses
// ---------------------------------------------------------------------------
module within_checker #(
    parameter int NCH       = 1,
    parameter int OUTER_LEN = 3,
    parameter int INNER_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr_cnt,
    input  logic [NCH-1:0]     a,
    input  logic [NCH-1:0]     b,
    input  logic [NCH-1:0]     c,
    output logic [NCH-1:0]     busy,
    output logic [NCH-1:0]     pass,
    output logic [NCH-1:0]     fail,
    output logic [2*NCH-1:0]   fail_code,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt
);

    localparam int CYC_W = $clog2(OUTER_LEN + 1);
    localparam int RUN_W = $clog2(INNER_LEN + 1);
    localparam int POP_W = $clog2(NCH + 1);
    localparam int SUM_W = CNT_W + POP_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OUTER = 2'd1;
    localparam logic [1:0] ST_TERM  = 2'd2;

    localparam logic [1:0] CODE_B_DROP = 2'b01;
    localparam logic [1:0] CODE_C_MISS = 2'b10;
    localparam logic [1:0] CODE_INNER  = 2'b11;

    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(INNER_LEN);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(OUTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Same-edge decisions of every channel, feeding the aggregate counters.
    logic [NCH-1:0] pass_vec_d;
    logic [NCH-1:0] fail_vec_d;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [1:0]       state_q, state_d;
        logic [CYC_W-1:0] cyc_q, cyc_d;
        logic [RUN_W-1:0] run_q, run_d;
        logic [RUN_W-1:0] run_base, run_next;
        logic             seen_q, seen_d;
        logic             seen_now;
        logic             b_prev_q;
        logic             armed_q;
        logic             busy_q, busy_d;
        logic             pass_q, pass_d;
        logic             fail_q, fail_d;
        logic [1:0]       code_q, code_d;
        logic             trigger;

        // armed_q blocks a trigger until b has been seen low after reset, so a
        // b that is already high when reset releases cannot open a window.
        assign trigger = b[g] & ~b_prev_q & armed_q;

        // A trigger starts the run count from zero; otherwise it continues.
        assign run_base = (state_q == ST_IDLE) ? '0 : run_q;
        assign run_next = !a[g]                ? '0
                        : (run_base == RUN_FULL) ? run_base
                        : run_base + RUN_W'(1);
        // Includes a run that completes on this very cycle.
        assign seen_now = (state_q != ST_IDLE && seen_q) || (run_next == RUN_FULL);

        // NOTE: every variable gets a default at the top of the block so no
        // path leaves it unassigned, which would otherwise infer a latch.
        always_comb begin
            state_d = state_q;
            cyc_d   = cyc_q;
            run_d   = run_q;
            seen_d  = seen_q;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            code_d  = code_q;
            if (!en) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (trigger) begin
                            run_d   = run_next;
                            seen_d  = seen_now;
                            cyc_d   = CYC_W'(1);
                            state_d = (OUTER_LEN == 1) ? ST_TERM : ST_OUTER;
                        end
                    end
                    ST_OUTER: begin
                        if (!b[g]) begin
                            fail_d  = 1'b1;
                            code_d  = CODE_B_DROP;
                            state_d = ST_IDLE;
                        end else begin
                            run_d  = run_next;
                            seen_d = seen_now;
                            cyc_d  = cyc_q + CYC_W'(1);
                            if (cyc_q == CYC_LAST) begin
                                state_d = ST_TERM;
                            end
                        end
                    end
                    ST_TERM: begin
                        state_d = ST_IDLE;
                        if (!c[g]) begin
                            fail_d = 1'b1;
                            code_d = CODE_C_MISS;
                        end else if (seen_now) begin
                            pass_d = 1'b1;
                        end else begin
                            fail_d = 1'b1;
                            code_d = CODE_INNER;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // busy covers the decision cycle too, dropping one edge after it.
        assign busy_d = (state_d != ST_IDLE) | pass_d | fail_d;

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                cyc_q    <= '0;
                run_q    <= '0;
                seen_q   <= 1'b0;
                b_prev_q <= 1'b0;
                armed_q  <= 1'b0;
                busy_q   <= 1'b0;
                pass_q   <= 1'b0;
                fail_q   <= 1'b0;
                code_q   <= 2'b00;
            end else begin
                state_q  <= state_d;
                cyc_q    <= cyc_d;
                run_q    <= run_d;
                seen_q   <= seen_d;
                b_prev_q <= b[g];
                armed_q  <= armed_q | ~b[g];
                busy_q   <= busy_d;
                pass_q   <= pass_d;
                fail_q   <= fail_d;
                code_q   <= code_d;
            end
        end

        assign busy[g]            = busy_q;
        assign pass[g]            = pass_q;
        assign fail[g]            = fail_q;
        assign fail_code[2*g +: 2] = code_q;
        assign pass_vec_d[g]      = pass_d;
        assign fail_vec_d[g]      = fail_d;
    end

    // Aggregate counters: add the popcount of this edge's decisions, clamp.
    logic [POP_W-1:0] pass_pop, fail_pop;
    logic [SUM_W-1:0] pass_sum, fail_sum;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    always_comb begin
        pass_pop = '0;
        fail_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            pass_pop = pass_pop + POP_W'(pass_vec_d[i]);
            fail_pop = fail_pop + POP_W'(fail_vec_d[i]);
        end
        pass_sum = SUM_W'(pass_cnt_q) + SUM_W'(pass_pop);
        fail_sum = SUM_W'(fail_cnt_q) + SUM_W'(fail_pop);
        pass_cnt_d = (pass_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : pass_sum[CNT_W-1:0];
        fail_cnt_d = (fail_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : fail_sum[CNT_W-1:0];
        if (clr_cnt) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_within_checker.sv
// ---------------------------------------------------------------------------
// tb_within_checker
//
// Two checkers share one stimulus: dut0 with default parameters, and dut1
// with two channels and 2-bit counters (channel 1 sees b only when m1s is
// set). Each scenario occupies a 100 ns slot; stimulus pushes the expected
// pulses into per-DUT queues and independent monitors pop them on the
// falling edge whenever a DUT pulses.
// ---------------------------------------------------------------------------
module tb_within_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, clr_cnt;
    logic       a, b, c;
    logic       m1s;

    logic       busy0, pass0, fail0;
    logic [1:0] code0;
    logic [15:0] pc0, fc0;

    logic [1:0] a1, b1, c1;
    logic [1:0] busy1, pass1, fail1;
    logic [3:0] code1;
    logic [1:0] pc1, fc1;

    assign a1 = {a, a};
    assign b1 = {b & m1s, b};
    assign c1 = {c, c};

    within_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .a(a), .b(b), .c(c),
        .busy(busy0), .pass(pass0), .fail(fail0), .fail_code(code0),
        .pass_cnt(pc0), .fail_cnt(fc0)
    );

    within_checker #(.NCH(2), .OUTER_LEN(3), .INNER_LEN(4), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .a(a1), .b(b1), .c(c1),
        .busy(busy1), .pass(pass1), .fail(fail1), .fail_code(code1),
        .pass_cnt(pc1), .fail_cnt(fc1)
    );

    typedef struct {
        longint      t;
        logic        p;
        logic        f;
        logic [1:0]  code;
        logic [15:0] pc;
        logic [15:0] fc;
    } exp0_t;

    typedef struct {
        longint     t;
        logic [1:0] p;
        logic [1:0] f;
        logic [1:0] pc;
        logic [1:0] fc;
    } exp1_t;

    exp0_t q0[$];
    exp1_t q1[$];
    exp0_t e0;
    exp1_t e1;

    int n_vec = 0;
    int n_err = 0;

    // Bench-side model of counters and last fail cause.
    int         ep0 = 0, ef0 = 0, ep1 = 0, ef1 = 0;
    logic [1:0] ecode = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor for dut0.
    always @(negedge clk) begin
        if (pass0 === 1'b1 || fail0 === 1'b1) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL dut0_unexpected_pulse at %0t: pass=%0b fail=%0b code=%b, expected no pulse",
                         $time - 5, pass0, fail0, code0);
            end else begin
                e0 = q0.pop_front();
                if (pass0 !== e0.p || fail0 !== e0.f || (e0.f && code0 !== e0.code) ||
                    pc0 !== e0.pc || fc0 !== e0.fc || ($time - 5) != e0.t) begin
                    n_err++;
                    $display("FAIL dut0_pulse: got t=%0d p=%0b f=%0b code=%b pc=%0d fc=%0d, expected t=%0d p=%0b f=%0b code=%b pc=%0d fc=%0d",
                             $time - 5, pass0, fail0, code0, pc0, fc0,
                             e0.t, e0.p, e0.f, e0.code, e0.pc, e0.fc);
                end
            end
        end
    end

    // Monitor for dut1.
    always @(negedge clk) begin
        if (|pass1 === 1'b1 || |fail1 === 1'b1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL dut1_unexpected_pulse at %0t: pass=%b fail=%b, expected no pulse",
                         $time - 5, pass1, fail1);
            end else begin
                e1 = q1.pop_front();
                if (pass1 !== e1.p || fail1 !== e1.f || pc1 !== e1.pc || fc1 !== e1.fc ||
                    ($time - 5) != e1.t) begin
                    n_err++;
                    $display("FAIL dut1_pulse: got t=%0d p=%b f=%b pc=%0d fc=%0d, expected t=%0d p=%b f=%b pc=%0d fc=%0d",
                             $time - 5, pass1, fail1, pc1, fc1, e1.t, e1.p, e1.f, e1.pc, e1.fc);
                end
            end
        end
    end

    // One 100 ns scenario. Ranges are [on, off) in ns relative to the slot;
    // kind: 0 no decision, 1 pass, 2 fail. chk_busy: 1 full window profile,
    // 2 window must never open.
    task automatic run_scn(input int b_on, input int b_off, input int a_on, input int a_off,
                           input int c_on, input int c_off, input int rst_on, input int rst_off,
                           input int enl_on, input int enl_off, input int clr_on, input int clr_off,
                           input bit m1, input int kind, input logic [1:0] code,
                           input int dec, input int chk_busy);
        longint t0;
        int     pop;
        exp0_t  x0;
        exp1_t  x1;
        t0  = $time;
        pop = m1 ? 2 : 1;
        if (kind != 0) begin
            if (kind == 1) begin
                ep0++;
                ep1 = (ep1 + pop > 3) ? 3 : ep1 + pop;
            end else begin
                ef0++;
                ef1 = (ef1 + pop > 3) ? 3 : ef1 + pop;
                ecode = code;
            end
            x0.t = t0 + dec; x0.p = (kind == 1); x0.f = (kind == 2); x0.code = code;
            x0.pc = 16'(ep0); x0.fc = 16'(ef0);
            q0.push_back(x0);
            x1.t = t0 + dec;
            x1.p = (kind == 1) ? {m1, 1'b1} : 2'b00;
            x1.f = (kind == 2) ? {m1, 1'b1} : 2'b00;
            x1.pc = 2'(ep1); x1.fc = 2'(ef1);
            q1.push_back(x1);
        end
        if (rst_off > rst_on) begin
            ep0 = 0; ef0 = 0; ep1 = 0; ef1 = 0; ecode = 2'b00;
        end
        if (clr_off > clr_on) begin
            ep0 = 0; ef0 = 0; ep1 = 0; ef1 = 0;
        end
        m1s = m1;
        for (int t = 0; t < 100; t++) begin
            b       = (t >= b_on && t < b_off);
            a       = (t >= a_on && t < a_off);
            c       = (t >= c_on && t < c_off);
            rst_n   = !(t >= rst_on && t < rst_off);
            en      = !(t >= enl_on && t < enl_off);
            clr_cnt = (t >= clr_on && t < clr_off);
            if (chk_busy == 1) begin
                if (t == 30) check("busy_before_trigger", 32'(busy0), 32'd0);
                if (t == 40) check("busy_after_trigger", 32'(busy0), 32'd1);
                if (t == 70) check("busy_decision_cycle", 32'(busy0), 32'd1);
                if (t == 80) check("busy_after_decision", 32'(busy0), 32'd0);
            end else if (chk_busy == 2) begin
                if (t == 60) check("busy_no_window_60", 32'(busy0), 32'd0);
                if (t == 70) check("busy_no_window_70", 32'(busy0), 32'd0);
            end
            if (t == 90) begin
                check("dut0_pass_cnt", 32'(pc0), 32'(ep0));
                check("dut0_fail_cnt", 32'(fc0), 32'(ef0));
                check("dut0_fail_code", 32'(code0), 32'(ecode));
                check("dut1_pass_cnt", 32'(pc1), 32'(ep1));
                check("dut1_fail_cnt", 32'(fc1), 32'(ef1));
                check("dut0_busy_idle", 32'(busy0), 32'd0);
            end
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clr_cnt = 1'b0;
        a = 1'b0; b = 1'b0; c = 1'b0; m1s = 1'b1;
        #2;
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_pass", 32'(pass0), 32'd0);
        check("reset_fail", 32'(fail0), 32'd0);
        check("reset_fail_code", 32'(code0), 32'd0);
        check("reset_pass_cnt", 32'(pc0), 32'd0);
        check("reset_fail_cnt", 32'(fc0), 32'd0);
        #10;
        rst_n = 1'b1;
        #(100 - $time);

        //       b        a        c        rst      en low   clr     m1 kind code   dec busy
        run_scn(28, 58,  28, 68,  63, 73,  0, 0,    0, 0,    0, 0,   1, 1, 2'b00, 65, 1); // pass
        run_scn(28, 58,  28, 48,  63, 73,  0, 0,    0, 0,    0, 0,   1, 2, 2'b11, 65, 0); // inner short
        run_scn(28, 48,  28, 68,  63, 73,  0, 0,    0, 0,    0, 0,   1, 2, 2'b01, 55, 0); // b drops
        run_scn(28, 58,  28, 68,   0,  0,  0, 0,    0, 0,    0, 0,   1, 2, 2'b10, 65, 0); // c missing
        run_scn(28, 58,  28, 68,  63, 73, 50, 52,   0, 0,    0, 0,   1, 0, 2'b00,  0, 2); // reset mid-window
        run_scn(28, 58,  28, 68,  63, 73,  0, 0,    0, 0,    0, 0,   1, 1, 2'b00, 65, 1); // pass, cnt1 -> 2
        run_scn(28, 58,  28, 68,  63, 73,  0, 0,    0, 0,    0, 0,   0, 1, 2'b00, 65, 0); // ch0 only, cnt1 -> 3
        run_scn(28, 58,  28, 68,  63, 73,  0, 0,    0, 0,   71, 79,  1, 1, 2'b00, 65, 0); // saturate, then clear
        run_scn(28, 58,  28, 68,  63, 73,  0, 0,   50, 60,   0, 0,   1, 0, 2'b00,  0, 2); // en low aborts
        run_scn(28, 48,  28, 68,  63, 73,  0, 0,    0, 0,    0, 0,   1, 2, 2'b01, 55, 0); // fail code held

        #50;
        check("dut0_queue_drained", 32'(q0.size()), 32'd0);
        check("dut1_queue_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
